// File: rtl/div_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_seq_pkg
// Purpose : shared types and default widths for the EX-stage multi-cycle
//           divide sequencer (div_seq) and its handshake interface.
// Contents: default operand / counter widths, the sequencer state enum and
//           the number of edges the divide-by-zero path dwells in BYZERO.
// ---------------------------------------------------------------------------
package div_seq_pkg;

    // Default operand width; the packed result is twice this wide.
    localparam int DIV_DATA_W = 32;

    // Default iteration counter width; must be able to count to DIV_DATA_W.
    localparam int DIV_CNT_W = 6;

    // A divide by zero still stalls the pipe for two edges before the
    // zero result shows up, so BYZERO is held for this many edges.
    localparam int DIV_ZERO_DWELL = 2;

    // Sequencer states.
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } divState_e;

endpackage

// File: rtl/div_seq_if.sv
// ---------------------------------------------------------------------------
// div_seq_if
// Purpose : handshake / operand bundle between the ID/EX control logic
//           (master) and the divide sequencer (slave).
// Signals : signed_div_i  1 = DIV (signed), 0 = DIVU
//           opdata1_i     dividend
//           opdata2_i     divisor
//           start_i       request, held until ready_o is seen
//           annul_i       abort the running operation (flush)
//           result_o      {remainder, quotient}
//           ready_o       result_o valid
//           busy_o        stall request while the divide runs
// ---------------------------------------------------------------------------
interface div_seq_if
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) ();

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    // Driving side: the pipeline control that issues divides.
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    // Receiving side: the divide sequencer itself.
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );

endinterface

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
// Purpose : multi-cycle DIV/DIVU sequencer for the EX stage. Latches the
//           operands on accept, runs a 1-bit-per-edge restoring division
//           and returns {remainder, quotient} for the HI/LO write. busy_o
//           stalls IF/ID/EX while the divide runs.
// Ports   : clk  rising-edge clock
//           rst  asynchronous, active-low reset
//           bus  div_seq_if.slave (operands, start/annul, result/ready/busy)
// ---------------------------------------------------------------------------
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);

    divState_e             state_q, state_d;
    logic [DATA_W-1:0]     dividend_q, dividend_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic [DATA_W-1:0]     partRem_q, partRem_d;
    logic [DATA_W-1:0]     quot_q, quot_d;
    logic                  negQuot_q, negQuot_d;
    logic                  negRem_q, negRem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   result_q, result_d;

    logic                  accept;
    logic                  lastIter;
    logic                  zeroDone;
    logic                  opANeg;
    logic                  opBNeg;
    logic [DATA_W-1:0]     absA;
    logic [DATA_W-1:0]     absB;
    logic [DATA_W:0]       shifted;
    logic [DATA_W:0]       trial;
    logic                  quotBit;
    logic [DATA_W-1:0]     nextRem;
    logic [DATA_W-1:0]     nextQuot;
    logic [DATA_W-1:0]     finalQuot;
    logic [DATA_W-1:0]     finalRem;

    // Operand conditioning. For a signed divide we work on magnitudes and
    // remember the signs; the most negative value maps onto itself, which is
    // still the right magnitude when read as unsigned.
    always_comb begin
        opANeg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
        opBNeg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
        absA   = opANeg ? -bus.opdata1_i : bus.opdata1_i;
        absB   = opBNeg ? -bus.opdata2_i : bus.opdata2_i;
        accept = bus.start_i & ~bus.annul_i;
    end

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and try to subtract the divisor with one extra bit
    // so the borrow tells us whether to keep or restore. The partial
    // remainder is always below the divisor, so both outcomes fit back
    // into DATA_W bits.
    always_comb begin
        shifted   = {partRem_q, dividend_q[DATA_W-1]};
        trial     = shifted - {1'b0, divisor_q};
        quotBit   = ~trial[DATA_W];
        nextRem   = quotBit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
        nextQuot  = {quot_q[DATA_W-2:0], quotBit};
        finalQuot = negQuot_q ? -nextQuot : nextQuot;
        finalRem  = negRem_q  ? -nextRem  : nextRem;
        lastIter  = (cnt_q == CNT_W'(DATA_W - 1));
        zeroDone  = (cnt_q == CNT_W'(DIV_ZERO_DWELL - 1));
    end

    // State register. Reset drops any operation in flight straight away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DivFree;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Annul beats start in FREE and aborts ON/BYZERO, but
    // once the result is presented in END only dropping start moves on.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DivFree: begin
                if (accept) begin
                    state_d = (bus.opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                if (bus.annul_i) begin
                    state_d = DivFree;
                end else if (zeroDone) begin
                    state_d = DivEnd;
                end
            end
            DivOn: begin
                if (bus.annul_i) begin
                    state_d = DivFree;
                end else if (lastIter) begin
                    state_d = DivEnd;
                end
            end
            DivEnd: begin
                if (!bus.start_i) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    // Datapath next-state. Operands are captured only on the accept edge so
    // later changes on the bus cannot disturb a running divide. The result
    // register is cleared whenever we leave an operation, so a stale value
    // never leaks into the next one.
    always_comb begin
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        partRem_d  = partRem_q;
        quot_d     = quot_q;
        negQuot_d  = negQuot_q;
        negRem_d   = negRem_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        case (state_q)
            DivFree: begin
                if (accept) begin
                    dividend_d = absA;
                    divisor_d  = absB;
                    negQuot_d  = opANeg ^ opBNeg;
                    negRem_d   = opANeg;
                    partRem_d  = '0;
                    quot_d     = '0;
                    cnt_d      = '0;
                    result_d   = '0;
                end
            end
            DivByZero: begin
                if (bus.annul_i || zeroDone) begin
                    cnt_d    = '0;
                    result_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DivOn: begin
                if (bus.annul_i) begin
                    cnt_d    = '0;
                    result_d = '0;
                end else begin
                    partRem_d  = nextRem;
                    quot_d     = nextQuot;
                    dividend_d = dividend_q << 1;
                    if (lastIter) begin
                        cnt_d    = '0;
                        result_d = {finalRem, finalQuot};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DivEnd: begin
                if (!bus.start_i) begin
                    result_d = '0;
                end
            end
            default: begin
                cnt_d    = '0;
                result_d = '0;
            end
        endcase
    end

    // Datapath registers, cleared together with the state on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            partRem_q  <= '0;
            quot_q     <= '0;
            negQuot_q  <= 1'b0;
            negRem_q   <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else begin
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            partRem_q  <= partRem_d;
            quot_q     <= quot_d;
            negQuot_q  <= negQuot_d;
            negRem_q   <= negRem_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
        end
    end

    // Outputs are plain decodes of registered state, so the stall request
    // and the ready flag never glitch on input changes.
    always_comb begin
        bus.busy_o   = (state_q == DivOn) || (state_q == DivByZero);
        bus.ready_o  = (state_q == DivEnd);
        bus.result_o = result_q;
    end

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
// Purpose : self-checking bench for div_seq. A transaction-level model
//           (latency countdown plus native integer division) predicts
//           busy/ready/result every cycle; directed cases pin the model
//           with hand-computed results, then random operations follow.
// ---------------------------------------------------------------------------
module tb_div_seq;

    logic clk;
    logic rst;

    int assertCount = 0;
    int failCount   = 0;

    div_seq_if #(.DATA_W(32)) bus ();

    div_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference quotient/remainder from plain integer arithmetic. SV
    // division truncates toward zero and the remainder follows the
    // dividend, which is exactly the MIPS DIV contract.
    function automatic logic [63:0] refDiv(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Behavioural model: an operation is simply "busy for N edges, then
    // ready with refDiv() until start drops"; annul or reset cancels it.
    int          mBusyLeft = 0;
    logic        mReady    = 1'b0;
    logic [63:0] mResult   = 64'd0;
    logic [63:0] mPending  = 64'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mBusyLeft = 0;
            mReady    = 1'b0;
            mResult   = 64'd0;
        end else if (mReady) begin
            if (!bus.start_i) begin
                mReady  = 1'b0;
                mResult = 64'd0;
            end
        end else if (mBusyLeft > 0) begin
            if (bus.annul_i) begin
                mBusyLeft = 0;
            end else begin
                mBusyLeft--;
                if (mBusyLeft == 0) begin
                    mReady  = 1'b1;
                    mResult = mPending;
                end
            end
        end else if (bus.start_i && !bus.annul_i) begin
            mBusyLeft = (bus.opdata2_i == 32'd0) ? 2 : 32;
            mPending  = refDiv(bus.signed_div_i, bus.opdata1_i, bus.opdata2_i);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    logic checkEn = 1'b0;
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_busy",   {63'd0, bus.busy_o},  {63'd0, (mBusyLeft > 0)});
            checkOutput("cyc_ready",  {63'd0, bus.ready_o}, {63'd0, mReady});
            checkOutput("cyc_result", bus.result_o,         mReady ? mResult : 64'd0);
        end
    end

    // Issue one divide from a negedge, wait (bounded) for ready, hold start
    // for 'hold' more cycles, then drop it and confirm the return to idle.
    task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input int hold, output logic [63:0] res, output int lat);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        @(posedge clk);
        // Scramble operands after accept; they must be ignored.
        #1 bus.opdata1_i = $urandom;
        bus.opdata2_i    = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!bus.ready_o && lat < 100);
        checkOutput("latency", 64'(lat), (b == 32'd0) ? 64'd2 : 64'd32);
        res = bus.result_o;
        checkOutput("result_vs_model", res, refDiv(s, a, b));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1 checkOutput("hold_result", bus.result_o, res);
            checkOutput("hold_ready", {63'd0, bus.ready_o}, 64'd1);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1 checkOutput("drop_ready", {63'd0, bus.ready_o}, 64'd0);
        checkOutput("drop_result", bus.result_o, 64'd0);
        @(negedge clk);
    endtask

    logic [63:0] res;
    int          lat;

    initial begin
        rst              = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy",   {63'd0, bus.busy_o},  64'd0);
        checkOutput("reset_ready",  {63'd0, bus.ready_o}, 64'd0);
        checkOutput("reset_result", bus.result_o,         64'd0);
        rst     = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);

        // Directed cases with hand-computed results; these also pin refDiv.
        applyStimulus(1'b0, 32'd100, 32'd7, 0, res, lat);
        checkOutput("divu_100_7", res, {32'd2, 32'd14});
        checkOutput("model_100_7", refDiv(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});

        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, res, lat);
        checkOutput("div_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        checkOutput("model_m7_2", refDiv(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 0, res, lat);
        checkOutput("div_7_m2", res, {32'd1, 32'hFFFF_FFFD});

        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat);
        checkOutput("div_minint_m1", res, {32'd0, 32'h8000_0000});
        checkOutput("model_minint_m1", refDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});

        applyStimulus(1'b0, 32'd5, 32'd0, 0, res, lat);
        checkOutput("divu_5_0", res, 64'd0);

        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 5, res, lat);
        checkOutput("divu_max_1", res, {32'd0, 32'hFFFF_FFFF});

        // Annul during ON: after the 10th edge, raise annul for one edge.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 bus.annul_i = 1'b1;
        bus.start_i    = 1'b0;
        @(posedge clk);
        #1 checkOutput("annul_busy", {63'd0, bus.busy_o}, 64'd0);
        checkOutput("annul_ready", {63'd0, bus.ready_o}, 64'd0);
        bus.annul_i = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 32'd9, 32'd3, 0, res, lat);
        checkOutput("divu_9_3_after_annul", res, {32'd0, 32'd3});

        // start and annul together in FREE: no operation begins.
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        @(posedge clk);
        #1 checkOutput("start_annul_busy", {63'd0, bus.busy_o}, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(negedge clk);

        // Asynchronous reset between edges in the middle of ON.
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        bus.start_i = 1'b0;
        #1 checkOutput("async_rst_busy",   {63'd0, bus.busy_o},  64'd0);
        checkOutput("async_rst_ready",  {63'd0, bus.ready_o}, 64'd0);
        checkOutput("async_rst_result", bus.result_o,         64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 32'd100, 32'd7, 0, res, lat);
        checkOutput("divu_100_7_after_rst", res, {32'd2, 32'd14});

        // Randomized operations, biased toward interesting divisors.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            logic        s;
            int          sel;
            s   = 1'($urandom_range(0, 1));
            a   = $urandom;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            applyStimulus(s, a, b, int'($urandom_range(0, 3)), res, lat);
        end

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
